// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned MASK_W      = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_M0, ARB_BUSY_M1} ArbState_t;
  typedef enum logic {ARB_M0, ARB_M1} MasterId_t;

  // Master-to-slave request payload routed through the arbiter mux.
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] data_wr;
    logic [MASK_W-1:0] mask;
  } bus_req_t;

endpackage

// File: rtl/bus_if.sv
// CPU-side memory bus: master drives the request, slave returns stall and read data.
interface Bus_if;
  import bus_arb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] data_wr;
  logic [MASK_W-1:0] mask;
  logic              stall;
  logic [DATA_W-1:0] data_rd;
  logic [DATA_W-1:0] data_rd_2;

  modport master (
    output address, read, write, data_wr, mask,
    input  stall, data_rd, data_rd_2
  );

  modport slave (
    input  address, read, write, data_wr, mask,
    output stall, data_rd, data_rd_2
  );

endinterface

// File: rtl/arb_pick.sv
// Combinational master selection for an idle bus.
// BUS_ARB_RR_EN selects round-robin; otherwise M0 has fixed priority.
module arb_pick
  import bus_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  MasterId_t last_grant,
  output logic      valid,
  output MasterId_t id
);

  assign valid = req0 | req1;

`ifdef BUS_ARB_RR_EN
  // Contention goes to whichever master did not complete last.
  always_comb begin
    id = ARB_M0;
    if (req0 && req1) begin
      id = (last_grant == ARB_M0) ? ARB_M1 : ARB_M0;
    end else if (req1) begin
      id = ARB_M1;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign id = req0 ? ARB_M0 : ARB_M1;
`endif

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Zero-latency 2:1 arbiter sharing one slave bus between data (M0) and fetch (M1) masters.
// Pick policy is chosen in arb_pick via BUS_ARB_RR_EN.
module bus_arbiter_2to1
  import bus_arb_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  Bus_if.slave  m0,
  Bus_if.slave  m1,
  Bus_if.master s
);

  ArbState_t state;
  ArbState_t state_next;
  MasterId_t last_grant;
  MasterId_t last_grant_next;
  MasterId_t pick_id;
  MasterId_t owner_id;
  logic      pick_valid;
  logic      owner_valid;
  logic      owner_req;
  logic      req0;
  logic      req1;
  bus_req_t  m0_req;
  bus_req_t  m1_req;
  bus_req_t  s_req;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .id         (pick_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= ARB_M1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Owner is locked while busy; an idle bus follows the live pick.
  always_comb begin
    owner_valid     = pick_valid;
    owner_id        = pick_id;
    state_next      = ARB_IDLE;
    last_grant_next = last_grant;
    case (state)
      ARB_BUSY_M0: begin
        owner_valid = 1'b1;
        owner_id    = ARB_M0;
      end
      ARB_BUSY_M1: begin
        owner_valid = 1'b1;
        owner_id    = ARB_M1;
      end
      default: ;
    endcase
    owner_req = (owner_id == ARB_M0) ? req0 : req1;
    if (owner_valid && owner_req) begin
      if (s.stall) begin
        state_next = (owner_id == ARB_M0) ? ARB_BUSY_M0 : ARB_BUSY_M1;
      end else begin
        last_grant_next = owner_id;
      end
    end
  end

  always_comb begin
    m0_req = '{address: m0.address, read: m0.read, write: m0.write,
               data_wr: m0.data_wr, mask: m0.mask};
    m1_req = '{address: m1.address, read: m1.read, write: m1.write,
               data_wr: m1.data_wr, mask: m1.mask};
    s_req  = '0;
    if (owner_valid) begin
      s_req = (owner_id == ARB_M0) ? m0_req : m1_req;
    end
  end

  assign s.address = s_req.address;
  assign s.read    = s_req.read;
  assign s.write   = s_req.write;
  assign s.data_wr = s_req.data_wr;
  assign s.mask    = s_req.mask;

  // Non-owner requesters wait; idle masters never see a stall.
  assign m0.stall = req0 & ((owner_valid && owner_id == ARB_M0) ? s.stall : 1'b1);
  assign m1.stall = req1 & ((owner_valid && owner_id == ARB_M1) ? s.stall : 1'b1);

  assign m0.data_rd   = s.data_rd;
  assign m0.data_rd_2 = s.data_rd_2;
  assign m1.data_rd   = s.data_rd;
  assign m1.data_rd_2 = s.data_rd_2;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Self-checking bench for bus_arbiter_2to1: vector table, directed sequences, random vs model.
module tb_bus_arbiter_2to1;
  import bus_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  Bus_if m0_bus ();
  Bus_if m1_bus ();
  Bus_if s_bus ();

  bus_arbiter_2to1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  localparam logic [31:0] A0  = 32'h0000_0010;
  localparam logic [31:0] A1  = 32'h1fc0_0000;
  localparam logic [31:0] WD0 = 32'hdead_beef;
  localparam logic [31:0] WD1 = 32'h0bad_f00d;
  localparam logic [31:0] RD  = 32'hcafe_f00d;
  localparam logic [31:0] RD2 = 32'h1234_5678;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: locked owner (-1 = none) and last completed master.
  int lock_id = -1;
  int last_id = 1;

  typedef struct packed {
    logic        r0, w0, r1, w1, st;
    logic        ex_rd, ex_wr;
    logic [31:0] ex_addr;
    logic [3:0]  ex_mask;
    logic        ex_st0, ex_st1;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input bit r0, input bit w0, input bit r1, input bit w1, input bit st);
    m0_bus.read  = r0;
    m0_bus.write = w0;
    m1_bus.read  = r1;
    m1_bus.write = w1;
    s_bus.stall  = st;
  endtask

  task automatic fixed_payload();
    m0_bus.address   = A0;
    m0_bus.data_wr   = WD0;
    m0_bus.mask      = 4'hf;
    m1_bus.address   = A1;
    m1_bus.data_wr   = WD1;
    m1_bus.mask      = 4'h3;
    s_bus.data_rd    = RD;
    s_bus.data_rd_2  = RD2;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    lock_id = -1;
    last_id = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] s_act();
    return 128'({s_bus.address, s_bus.read, s_bus.write, s_bus.data_wr, s_bus.mask});
  endfunction

  function automatic logic [127:0] bus_of(input int own);
    if (own == 0)
      return 128'({m0_bus.address, m0_bus.read, m0_bus.write, m0_bus.data_wr, m0_bus.mask});
    if (own == 1)
      return 128'({m1_bus.address, m1_bus.read, m1_bus.write, m1_bus.data_wr, m1_bus.mask});
    return 128'(0);
  endfunction

  task automatic expect_cycle(input string name, input int own, input bit st0, input bit st1);
    chk({name, "_bus"}, s_act(), bus_of(own));
    chk({name, "_stall"}, 128'({m0_bus.stall, m1_bus.stall}), 128'({st0, st1}));
  endtask

  function automatic int model_owner();
    bit q0 = m0_bus.read | m0_bus.write;
    bit q1 = m1_bus.read | m1_bus.write;
    if (lock_id >= 0) return lock_id;
    if (!q0 && !q1) return -1;
    if (q0 && q1) begin
`ifdef BUS_ARB_RR_EN
      return 1 - last_id;
`else
      return 0;
`endif
    end
    return q0 ? 0 : 1;
  endfunction

  task automatic model_step(input int own);
    bit rq;
    rq = (own == 0) ? (m0_bus.read | m0_bus.write) :
         (own == 1) ? (m1_bus.read | m1_bus.write) : 1'b0;
    lock_id = (rq && s_bus.stall) ? own : -1;
    if (rq && !s_bus.stall) last_id = own;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    fixed_payload();
    do_reset();

    // Table vectors from an idle bus; requests drop before each edge so nothing completes.
    vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 32'h0, 4'h0, 1'b0,1'b0};
    vecs[1] = '{1'b1,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0, A0,    4'hf, 1'b1,1'b1};
    vecs[2] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1, A0,    4'hf, 1'b0,1'b1};
    vecs[3] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0, A1,    4'h3, 1'b0,1'b0};
    vecs[4] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0, A1,    4'h3, 1'b0,1'b1};
    vecs[5] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0, A0,    4'hf, 1'b0,1'b0};
    vecs[6] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1, A0,    4'hf, 1'b1,1'b0};
    vecs[7] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1, A1,    4'h3, 1'b0,1'b0};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].r1, vecs[i].w1, vecs[i].st);
      #1;
      chk($sformatf("vec%0d_bus", i),
          128'({s_bus.read, s_bus.write, s_bus.address, s_bus.mask}),
          128'({vecs[i].ex_rd, vecs[i].ex_wr, vecs[i].ex_addr, vecs[i].ex_mask}));
      chk($sformatf("vec%0d_stall", i), 128'({m0_bus.stall, m1_bus.stall}),
          128'({vecs[i].ex_st0, vecs[i].ex_st1}));
      chk($sformatf("vec%0d_rdata", i),
          128'({m0_bus.data_rd, m1_bus.data_rd, m1_bus.data_rd_2}), 128'({RD, RD, RD2}));
      drive(0, 0, 0, 0, 0);
      next_cycle();
    end

    // Contention with a two-cycle slave stall, then M1 takes over.
    do_reset();
    drive(0, 1, 1, 0, 1); #1; expect_cycle("cont_c0", 0, 1, 1); next_cycle();
    drive(0, 1, 1, 0, 1); #1; expect_cycle("cont_c1", 0, 1, 1); next_cycle();
    drive(0, 1, 1, 0, 0); #1; expect_cycle("cont_c2", 0, 0, 1); next_cycle();
    drive(0, 0, 1, 0, 0); #1; expect_cycle("cont_m1", 1, 0, 0); next_cycle();

    // Both masters requesting continuously with a ready slave.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      int own;
`ifdef BUS_ARB_RR_EN
      own = i % 2;
`else
      own = 0;
`endif
      drive(1, 0, 1, 0, 0); #1;
      expect_cycle($sformatf("both_c%0d", i), own, own != 0, own != 1);
      next_cycle();
    end

    // M0 abandons while locked; pending M1 gets the bus next cycle.
    do_reset();
    drive(1, 0, 1, 0, 1); #1; expect_cycle("abn_lock", 0, 1, 1); next_cycle();
    drive(0, 0, 1, 0, 1); #1; expect_cycle("abn_drop", 0, 0, 1); next_cycle();
    drive(0, 0, 1, 0, 0); #1; expect_cycle("abn_m1", 1, 0, 0); next_cycle();

    // Reset asserted while M1 holds the bus.
    do_reset();
    drive(0, 0, 1, 0, 1); #1; expect_cycle("rst_pre", 1, 0, 1); next_cycle();
    drive(1, 0, 1, 0, 1); #1; expect_cycle("rst_busy", 1, 1, 1);
    rst_n = 1'b0;
    #1; expect_cycle("rst_pick", 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    #1; expect_cycle("rst_idle", -1, 0, 0);
    next_cycle();
    rst_n = 1'b1;

    // Idle bus.
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1; expect_cycle($sformatf("idle_c%0d", i), -1, 0, 0);
      next_cycle();
    end

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int own;
      int k0, k1;
      k0 = $urandom_range(0, 4);
      k1 = $urandom_range(0, 4);
      m0_bus.address = $urandom; m0_bus.data_wr = $urandom; m0_bus.mask = 4'($urandom);
      m1_bus.address = $urandom; m1_bus.data_wr = $urandom; m1_bus.mask = 4'($urandom);
      s_bus.data_rd = $urandom; s_bus.data_rd_2 = $urandom;
      drive(k0 == 1 || k0 == 2, k0 == 3, k1 == 1 || k1 == 2, k1 == 3, $urandom_range(0, 2) == 0);
      #1;
      own = model_owner();
      expect_cycle($sformatf("rnd%0d", i), own,
                   (m0_bus.read | m0_bus.write) && (own == 0 ? s_bus.stall : 1'b1),
                   (m1_bus.read | m1_bus.write) && (own == 1 ? s_bus.stall : 1'b1));
      chk($sformatf("rnd%0d_rdata", i),
          128'({m0_bus.data_rd, m1_bus.data_rd, m0_bus.data_rd_2, m1_bus.data_rd_2}),
          128'({s_bus.data_rd, s_bus.data_rd, s_bus.data_rd_2, s_bus.data_rd_2}));
      @(posedge clk);
      model_step(own);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
